instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter FQ_DEPTH, 2, fetch-queue entries; fixed at 2 in this revision.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Stall  input  1  hazard hold from decode; 1 = IF/ID not accepting.
REQ-006 Branch_Control  input  1  redirect request (taken branch or jump).
REQ-007 Branch_Target  input  32  redirect address.
REQ-008 Imem_Req_Valid  output  1  instruction-memory request valid.
REQ-009 Imem_Req_Ready  input  1  memory accepts request this cycle.
REQ-010 Imem_Addr  output  32  request address, word-aligned.
REQ-011 Imem_Resp_Valid  input  1  in-order response valid, one per accepted request, latency >= 1.
REQ-012 Imem_Resp_Data  input  32  fetched instruction word.
REQ-013 Instruction_out  output  32  instruction to IF/ID Instruction_in.
REQ-014 PC_out  output  32  fetch address + 4 to IF/ID PC_in.
REQ-015 Fetch_Valid  output  1  Instruction_out/PC_out hold a real instruction.

Function
REQ-016 Fetch PC register SHALL advance by 4 on every accepted request (Imem_Req_Valid && Imem_Req_Ready) absent redirect.
REQ-017 Imem_Req_Valid SHALL be 1 only when outstanding + queue occupancy < FQ_DEPTH; Imem_Addr = fetch PC.
REQ-018 Outstanding counter (0..2) SHALL +1 on accepted request, -1 on response, both or neither = unchanged.
REQ-019 Responses SHALL be written into the 2-entry FIFO tagged with address + 4, in order.
REQ-020 Fetch_Valid SHALL equal queue non-empty; Instruction_out/PC_out SHALL show queue head, else 32'h00000000 (NOP) and 32'h00000000.
REQ-021 Head SHALL pop when Fetch_Valid && !Stall; push and pop in same cycle SHALL keep occupancy unchanged.
REQ-022 Stall SHALL hold head outputs unchanged; requests continue until credit limit (REQ-017) reached.
REQ-023 Branch_Control SHALL, same edge: flush queue, load fetch PC with Branch_Target, set drop counter = outstanding after this cycle's accept/response updates.
REQ-024 While drop counter > 0, each response SHALL be discarded and decrement it; no queue write.
REQ-025 A request accepted in the redirect cycle SHALL be counted for drop; Imem_Req_Valid MAY deassert/change address in the redirect cycle only.
REQ-026 Outside redirect, Imem_Req_Valid once high SHALL stay high with stable Imem_Addr until accepted.
REQ-027 Branch_Control SHALL take priority over Stall; Fetch_Valid SHALL be 0 the cycle after redirect.
REQ-028 Queue full plus response SHALL not occur (credit rule); verification SHALL assert it never happens.
REQ-029 PC SHALL wrap 32'hFFFFFFFC -> 32'h00000000 silently.

Reset
REQ-030 On reset low, asynchronously: fetch PC = RESET_PC, queue empty, outstanding = 0, drop = 0, Fetch_Valid = 0, Instruction_out = 0, PC_out = 0, Imem_Req_Valid = 0.
REQ-031 First request SHALL issue in the first cycle after reset deasserts; responses arriving during reset are ignored.
REQ-032 Reset mid-operation SHALL discard all in-flight state; memory-side responses for pre-reset requests are the memory's responsibility.

Structure
REQ-033 Shared package SHALL hold RESET_PC default, NOP encoding 32'h00000000, and instruction/address width 32.
REQ-034 Queue SHALL be a sub-module fetch_queue (2-entry FIFO, push/pop/flush, full/empty); counters and PC logic in top.

Verification
REQ-035 Reset, Ready=1, one-cycle latency, Stall=0 -> Imem_Addr 0,4,8..., Fetch_Valid=1 from cycle 2, PC_out 4,8,12 per cycle.
REQ-036 Stall=1 for 5 cycles after first fetch -> outputs frozen on instr @0, PC_out=4; at most 2 requests issued; resume yields @4,@8 in order, no loss.
REQ-037 Branch_Control=1, Branch_Target=32'h00000100 with 2 outstanding -> next two responses dropped, next Imem_Addr=0x100, first Fetch_Valid shows PC_out=0x104.
REQ-038 Branch_Control and Stall both 1 -> queue flushed, Fetch_Valid=0 next cycle.
REQ-039 Imem_Req_Ready=0 for 3 cycles -> Imem_Req_Valid high, Imem_Addr stable.
REQ-040 Reset low mid-stream -> all outputs zero immediately; refetch from 0x0 after release.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, reset/NOP constants and fetch-queue entry type.
package instruction_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched instructions with push/pop/flush; head reads as NOP when empty.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  fq_entry_t data_i,
  output fq_entry_t head_o,
  output logic      full_o,
  output logic      empty_o,
  output logic [1:0] count_o
);
  fq_entry_t mem_q [2];
  logic rd_q, wr_q;
  logic [1:0] cnt_q;
  assign full_o = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign count_o = cnt_q;
  assign head_o = empty_o ? fq_entry_t'{instr: NOP, pc: '0} : mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: credit-limited instruction fetch with in-order response queue and branch redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            Branch_Control,
  input  logic [XLEN-1:0] Branch_Target,
  output logic            Imem_Req_Valid,
  input  logic            Imem_Req_Ready,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic            Imem_Resp_Valid,
  input  logic [XLEN-1:0] Imem_Resp_Data,
  output logic [XLEN-1:0] Instruction_out,
  output logic [XLEN-1:0] PC_out,
  output logic            Fetch_Valid
);
  logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d;
  logic [1:0] out_q, out_d, drop_q, drop_d, occ;
  logic accept, dropping, push, pop, full, empty;
  fq_entry_t head;
  // Requests plus already-queued words never exceed the queue size, so a response always has a slot.
  assign Imem_Req_Valid = reset && ({1'b0, out_q} + {1'b0, occ} < 3'(FQ_DEPTH));
  assign Imem_Addr = pc_q;
  assign accept = Imem_Req_Valid && Imem_Req_Ready;
  assign dropping = Imem_Resp_Valid && drop_q != 2'd0;
  assign push = Imem_Resp_Valid && !dropping && !full;
  assign pop = !empty && !Stall;
  assign Fetch_Valid = !empty;
  assign Instruction_out = head.instr;
  assign PC_out = head.pc;
  // rpc tracks the address of the next kept response: kept requests are sequential from the last redirect.
  always_comb begin
    out_d = out_q + 2'(accept) - 2'(Imem_Resp_Valid);
    drop_d = Branch_Control ? out_d : drop_q - 2'(dropping);
    pc_d = Branch_Control ? word_align(Branch_Target) : accept ? pc_q + 32'd4 : pc_q;
    rpc_d = Branch_Control ? word_align(Branch_Target) : push ? rpc_q + 32'd4 : rpc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      rpc_q <= RESET_PC;
      out_q <= 2'd0;
      drop_q <= 2'd0;
    end else begin
      pc_q <= pc_d;
      rpc_q <= rpc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue u_fq (
    .clk    (clk),
    .rst_n  (reset),
    .flush_i(Branch_Control),
    .push_i (push),
    .pop_i  (pop),
    .data_i (fq_entry_t'{instr: Imem_Resp_Data, pc: rpc_q + 32'd4}),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(occ)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic checked against a queue-based reference model.
module tb_instruction_fetch_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic Stall = 1'b0, Branch_Control = 1'b0, Imem_Req_Ready = 1'b0, Imem_Resp_Valid = 1'b0;
  logic [31:0] Branch_Target = '0, Imem_Resp_Data = '0;
  logic Imem_Req_Valid, Fetch_Valid;
  logic [31:0] Imem_Addr, Instruction_out, PC_out;
  int n_tests = 0, n_fail = 0;
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Branch_Control(Branch_Control),
    .Branch_Target(Branch_Target), .Imem_Req_Valid(Imem_Req_Valid), .Imem_Req_Ready(Imem_Req_Ready),
    .Imem_Addr(Imem_Addr), .Imem_Resp_Valid(Imem_Resp_Valid), .Imem_Resp_Data(Imem_Resp_Data),
    .Instruction_out(Instruction_out), .PC_out(PC_out), .Fetch_Valid(Fetch_Valid)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  mreq_t mem[$];
  ent_t fq[$];
  logic [31:0] m_pc = '0;
  int epoch = 0, cyc = 0;
  bit last_acc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  // Called at negedge+1; checks visible state, drives this cycle's inputs, advances the model and one clock.
  task automatic step(input bit rdy, input bit stl, input bit br, input logic [31:0] tgt,
                      input int lmin, input int lmax);
    bit exp_rv, fv, rsp;
    mreq_t h;
    exp_rv = mem.size() + fq.size() < 2;
    fv = fq.size() != 0;
    chk("req_valid", Imem_Req_Valid, exp_rv);
    if (exp_rv) chk("req_addr", Imem_Addr, m_pc);
    chk("fetch_valid", Fetch_Valid, fv);
    chk("instr_out", Instruction_out, fv ? fq[0].instr : 32'h0);
    chk("pc_out", PC_out, fv ? fq[0].pc : 32'h0);
    rsp = mem.size() != 0 && mem[0].due <= cyc;
    Stall = stl;
    Branch_Control = br;
    Branch_Target = tgt;
    Imem_Req_Ready = rdy;
    Imem_Resp_Valid = rsp;
    Imem_Resp_Data = rsp ? word_at(mem[0].addr) : $urandom;
    #1;
    chk("full_resp", {31'b0, dut.u_fq.full_o & Imem_Resp_Valid}, 32'h0);
    last_acc = exp_rv && rdy;
    if (fv && !stl) void'(fq.pop_front());
    if (rsp) begin
      h = mem.pop_front();
      if (h.epoch == epoch) fq.push_back('{instr: word_at(h.addr), pc: h.addr + 32'd4});
    end
    if (last_acc) mem.push_back('{addr: m_pc, epoch: epoch, due: cyc + 1 + int'($urandom_range(lmax, lmin))});
    if (br) begin
      fq.delete();
      epoch++;
      m_pc = tgt;
    end else if (last_acc) m_pc += 32'd4;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    Imem_Resp_Valid = 1'b1;
    Imem_Resp_Data = $urandom;
    Stall = 1'b0;
    Branch_Control = 1'b0;
    Imem_Req_Ready = 1'b1;
    #1;
    chk("rst_req_valid", Imem_Req_Valid, 32'h0);
    chk("rst_addr", Imem_Addr, 32'h0);
    chk("rst_fetch_valid", Fetch_Valid, 32'h0);
    chk("rst_instr", Instruction_out, 32'h0);
    chk("rst_pc_out", PC_out, 32'h0);
    mem.delete();
    fq.delete();
    m_pc = 32'h0;
    epoch++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    Imem_Resp_Valid = 1'b0;
    #1;
  endtask
  initial begin
    int nreq;
    logic [31:0] a0, tgt;
    apply_reset();
    // Streaming at unit latency; model tracks order and credit timing.
    repeat (12) step(1, 0, 0, 0, 0, 0);
    // Hold decode for five cycles after the first fetch.
    apply_reset();
    for (int i = 0; i < 10 && !Fetch_Valid; i++) step(1, 0, 0, 0, 0, 0);
    chk("first_fv", Fetch_Valid, 32'h1);
    nreq = 0;
    repeat (5) begin
      step(1, 1, 0, 0, 0, 0);
      nreq += int'(last_acc);
      chk("stall_pc", PC_out, 32'h4);
    end
    chk("stall_reqs", {31'b0, nreq <= 2}, 32'h1);
    repeat (8) step(1, 0, 0, 0, 0, 0);
    // Redirect with two requests outstanding.
    apply_reset();
    step(1, 0, 0, 0, 3, 3);
    step(1, 0, 0, 0, 3, 3);
    step(1, 0, 1, 32'h100, 0, 0);
    chk("br_addr", Imem_Addr, 32'h100);
    for (int i = 0; i < 30 && !Fetch_Valid; i++) step(1, 0, 0, 0, 0, 0);
    chk("br_first_pc", PC_out, 32'h104);
    // Redirect while stalled with a non-empty queue.
    repeat (4) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h200, 0, 0);
    chk("br_stall_fv", Fetch_Valid, 32'h0);
    // Memory not ready: request must hold.
    apply_reset();
    a0 = Imem_Addr;
    repeat (3) begin
      step(0, 0, 0, 0, 0, 0);
      chk("nordy_valid", Imem_Req_Valid, 32'h1);
      chk("nordy_addr", Imem_Addr, a0);
    end
    // Address wrap at the top of memory.
    step(1, 0, 1, 32'hFFFF_FFF8, 0, 0);
    repeat (10) step(1, 0, 0, 0, 0, 0);
    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(3, 0) << 2) : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, tgt, 0, 3);
      if (i % 700 == 699) apply_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
